// File: rtl/regfile_2r1w_if.sv
// ---------------------------------------------------------------------------
// regfile_2r1w_if
//   Bus bundle for the 2-read / 1-write register file.
//   master : drives write/address/data/clear, receives read data and valid.
//   slave  : the register file itself.
//   Signals:
//     write, writenum, data_in   write port
//     clear_valid                clear every entry's valid bit (data kept)
//     readnum_a, readnum_b       read addresses
//     data_a, data_b             read data
//     valid_a, valid_b           addressed entry holds a written value
// ---------------------------------------------------------------------------
interface regfile_2r1w_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             write;
  logic [AW-1:0]    writenum;
  logic [WIDTH-1:0] data_in;
  logic             clear_valid;
  logic [AW-1:0]    readnum_a;
  logic [AW-1:0]    readnum_b;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             valid_a;
  logic             valid_b;

  modport master (
    output write, writenum, data_in, clear_valid, readnum_a, readnum_b,
    input  data_a, data_b, valid_a, valid_b
  );

  modport slave (
    input  write, writenum, data_in, clear_valid, readnum_a, readnum_b,
    output data_a, data_b, valid_a, valid_b
  );
endinterface

// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
//   Parametrised register file, two independent read ports, one write port,
//   with per-entry valid tracking. Feeds the ALU A/B operands.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset; clears data, valid and outputs
//     bus      regfile_2r1w_if.slave (write port, clear_valid, read ports)
//   Parameters:
//     WIDTH    data bits per register
//     DEPTH    number of registers (2..256, any value)
//     READ_REG 0 = combinational read, 1 = registered read (1-cycle latency)
//     BYPASS   1 = same-cycle write to the read address is forwarded
//     AW       address width, derived from DEPTH
// ---------------------------------------------------------------------------
module regfile_2r1w #(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 8,
  parameter  int READ_REG = 0,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset_n,
  regfile_2r1w_if.slave  bus
);

  // One extra bit so DEPTH itself is representable for range compares.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;

  logic             wr_en;
  logic             in_range_a, in_range_b;
  logic [WIDTH-1:0] look_data_a, look_data_b;
  logic             look_valid_a, look_valid_b;

  // Addresses past DEPTH (non-power-of-two depths) never touch the array.
  assign wr_en      = bus.write && ({1'b0, bus.writenum} < DEPTH_W);
  assign in_range_a = {1'b0, bus.readnum_a} < DEPTH_W;
  assign in_range_b = {1'b0, bus.readnum_b} < DEPTH_W;

  // -------------------------------------------------------------------------
  // Storage and valid bits
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the array is reset because the design must read back zero after
      // reset; this makes it a flop array rather than an inferable RAM.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid <= '0;
    end else begin
      // NOTE: with non-blocking assignments the last one in program order
      // wins, so the write below overrides clear_valid for its own entry.
      if (bus.clear_valid) valid <= '0;
      if (wr_en) begin
        mem[bus.writenum]   <= bus.data_in;
        valid[bus.writenum] <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read lookup, including optional write-to-read forwarding
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    look_data_a  = '0;
    look_valid_a = 1'b0;
    if (in_range_a) begin
      look_data_a  = mem[bus.readnum_a];
      look_valid_a = valid[bus.readnum_a];
    end
    if (BYPASS != 0 && wr_en && bus.writenum == bus.readnum_a) begin
      look_data_a  = bus.data_in;
      look_valid_a = 1'b1;
    end
  end

  always_comb begin
    look_data_b  = '0;
    look_valid_b = 1'b0;
    if (in_range_b) begin
      look_data_b  = mem[bus.readnum_b];
      look_valid_b = valid[bus.readnum_b];
    end
    if (BYPASS != 0 && wr_en && bus.writenum == bus.readnum_b) begin
      look_data_b  = bus.data_in;
      look_valid_b = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
  if (READ_REG != 0) begin : g_reg_read
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        bus.data_a  <= '0;
        bus.data_b  <= '0;
        bus.valid_a <= 1'b0;
        bus.valid_b <= 1'b0;
      end else begin
        bus.data_a  <= look_data_a;
        bus.data_b  <= look_data_b;
        bus.valid_a <= look_valid_a;
        bus.valid_b <= look_valid_b;
      end
    end
  end else begin : g_comb_read
    assign bus.data_a  = look_data_a;
    assign bus.data_b  = look_data_b;
    assign bus.valid_a = look_valid_a;
    assign bus.valid_b = look_valid_b;
  end

endmodule
